// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind valid/ready request and response
// channels, with a fixed number of wait states before each access.
module dmem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] txn_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int unsigned CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic          t_we;
    logic [31:0]   t_addr;
    logic [31:0]   t_wdata;
    logic [31:0]   mem [DEPTH];

    logic [29:0]   idx;
    logic [AW-1:0] ram_idx;
    logic          addr_err;
    logic          access;

    assign idx        = t_addr[31:2];
    assign ram_idx    = idx[AW-1:0];
    assign addr_err   = (t_addr[1:0] != 2'b00) || ({2'b00, idx} >= DEPTH);
    assign access     = (state == BUSY) && (wait_cnt == '0);
    assign resp_valid = (state == RESP);

    // RAM has no reset; a reset during BUSY leaves state out of BUSY, so the write is dropped.
    always_ff @(posedge clk) begin
        if (access && t_we && !addr_err) begin
            mem[ram_idx] <= t_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            txn_count  <= '0;
            wait_cnt   <= '0;
            t_we       <= 1'b0;
            t_addr     <= '0;
            t_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        t_we      <= req_we;
                        t_addr    <= req_addr;
                        t_wdata   <= req_wdata;
                        wait_cnt  <= CW'(LATENCY);
                        state     <= BUSY;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        resp_err   <= addr_err;
                        resp_rdata <= (addr_err || t_we) ? '0 : mem[ram_idx];
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        txn_count  <= txn_count + 1'b1;
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule
